// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bits needed to hold any value in 0..max_value.
    function automatic int width_for(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO with level counter and drop indication.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_valid = !o_empty;
    assign o_level = r_level;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_drop = i_push && o_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, bit timer, frame FSM and receive FIFO.
// Define UART_RX_PARITY_EN to check one parity bit between data and stop bits.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          CLK,
    input  logic                          reset_n,
    input  logic                          serial_in,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          error_clear,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          overrun
);

    localparam int TW = width_for(CLKS_PER_BIT);
    localparam int BW = width_for(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    logic                 r_sync1;
    logic                 r_rxs;
    rx_state_t            r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_push;
    logic                 r_frame_err_set;
    logic                 r_frame_error;
    logic                 r_overrun;
    logic                 w_expired;
    logic                 w_drop;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_rxs   <= r_sync1;
        end
    end

    assign w_expired = (r_timer == '0);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    logic r_frame_bad;
    logic r_par_err_set;
    logic r_parity_error;
`endif

    // Each timed state acts only when the timer has counted down to zero.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_timer         <= '0;
            r_bit_idx       <= '0;
            r_stop_idx      <= 1'b0;
            r_shift         <= '0;
            r_push          <= 1'b0;
            r_frame_err_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_frame_bad     <= 1'b0;
            r_par_err_set   <= 1'b0;
`endif
        end else begin
            r_push          <= 1'b0;
            r_frame_err_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err_set   <= 1'b0;
`endif
            if (!w_expired) begin
                r_timer <= r_timer - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!r_rxs) begin
                        r_timer <= HALF_LOAD;
                        r_state <= START;
`ifdef UART_RX_PARITY_EN
                        r_frame_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (w_expired) begin
                        if (r_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_timer   <= FULL_LOAD;
                        end
                    end
                end
                DATA: begin
                    if (w_expired) begin
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        r_timer <= FULL_LOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx  <= '0;
                            r_stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_state    <= PARITY;
`else
                            r_state    <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_expired) begin
                        r_frame_bad <= (r_rxs != ((^r_shift) ^ PAR_MODE));
                        r_timer     <= FULL_LOAD;
                        r_state     <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_expired) begin
                        if (!r_rxs) begin
                            r_frame_err_set <= 1'b1;
                            r_state         <= WAIT_IDLE;
                        end else if (r_stop_idx == LAST_STOP) begin
`ifdef UART_RX_PARITY_EN
                            r_push        <= !r_frame_bad;
                            r_par_err_set <= r_frame_bad;
`else
                            r_push        <= 1'b1;
`endif
                            r_state <= IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_timer    <= FULL_LOAD;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (r_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (reset_n),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_pop   (rd_ready),
        .o_valid (rd_valid),
        .o_data  (rd_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

    // A clear wins over a set arriving in the same cycle.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (error_clear) begin
                r_frame_error <= 1'b0;
                r_overrun     <= 1'b0;
            end else begin
                if (r_frame_err_set) begin
                    r_frame_error <= 1'b1;
                end
                if (w_drop) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_error <= 1'b0;
        end else if (error_clear) begin
            r_parity_error <= 1'b0;
        end else if (r_par_err_set) begin
            r_parity_error <= 1'b1;
        end
    end
    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param with 4 clocks per bit and a 4-deep FIFO.
// Parity checks are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

    localparam int CPB = 4;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_level;
    logic       error_clear;
    logic       frame_error;
    logic       parity_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expPush;
        logic       expFrameErr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_param #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .PARITY_ODD   (0),
        .STOP_BITS    (1)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .error_clear  (error_clear),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overrun      (overrun)
    );

    always #5 CLK = ~CLK;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive one frame LSB first; the line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit);
        serial_in = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        serial_in = parBit;
        cycles(CPB);
`else
        if (parBit === 1'bx) $display("[TB] unexpected parity argument");
`endif
        serial_in = stopBit;
        cycles(CPB);
    endtask

    task automatic waitValid(input string name, input int limit);
        int n = 0;
        while (!rd_valid && n < limit) begin
            cycles(1);
            n++;
        end
        checkOutput(name, {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic popOne();
        rd_ready = 1'b1;
        cycles(1);
        rd_ready = 1'b0;
    endtask

    task automatic pulseClear();
        error_clear = 1'b1;
        cycles(1);
        error_clear = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h6E, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0};

        reset_n     = 1'b0;
        serial_in   = 1'b1;
        rd_ready    = 1'b0;
        error_clear = 1'b0;
        cycles(3);
        checkOutput("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("reset rd_data", {24'd0, rd_data}, 32'd0);
        reset_n = 1'b1;
        cycles(4);
        checkOutput("idle rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("idle fifo_empty", {31'd0, fifo_empty}, 32'd1);
        checkOutput("idle fifo_full", {31'd0, fifo_full}, 32'd0);
        checkOutput("idle fifo_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("idle flags", {29'd0, frame_error, parity_error, overrun}, 32'd0);

        // 0xA5: not yet visible at the end of the stop bit, visible within a few cycles.
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        serial_in = 1'b1;
        checkOutput("A5 not early", {31'd0, rd_valid}, 32'd0);
        waitValid("A5 latency", 4);
        checkOutput("A5 data", {24'd0, rd_data}, 32'hA5);
        checkOutput("A5 level", {29'd0, fifo_level}, 32'd1);
        popOne();
        checkOutput("A5 popped empty", {31'd0, fifo_empty}, 32'd1);
        popOne();
        checkOutput("pop while empty", {29'd0, fifo_level}, 32'd0);

        // Short low glitch must be rejected as a false start.
        serial_in = 1'b0;
        cycles(2);
        serial_in = 1'b1;
        cycles(20);
        checkOutput("glitch no push", {31'd0, rd_valid}, 32'd0);
        checkOutput("glitch no flags", {29'd0, frame_error, parity_error, overrun}, 32'd0);
        applyStimulus(8'h5A, 1'b1, ^8'h5A);
        serial_in = 1'b1;
        waitValid("post glitch valid", 6);
        checkOutput("post glitch data", {24'd0, rd_data}, 32'h5A);
        popOne();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stopBit, ^vecs[i].data);
            serial_in = 1'b1;
            if (vecs[i].expPush) begin
                waitValid($sformatf("vec%0d valid", i), 6);
                checkOutput($sformatf("vec%0d data", i), {24'd0, rd_data}, {24'd0, vecs[i].data});
            end else begin
                cycles(8);
                checkOutput($sformatf("vec%0d no push", i), {31'd0, rd_valid}, 32'd0);
            end
            checkOutput($sformatf("vec%0d frame_error", i), {31'd0, frame_error}, {31'd0, vecs[i].expFrameErr});
            checkOutput($sformatf("vec%0d parity_error", i), {31'd0, parity_error}, 32'd0);
            if (vecs[i].expPush) popOne();
            pulseClear();
            checkOutput($sformatf("vec%0d empty after", i), {31'd0, fifo_empty}, 32'd1);
            checkOutput($sformatf("vec%0d cleared", i), {31'd0, frame_error}, 32'd0);
            cycles(2);
        end

        // Fill the FIFO, then one more frame overruns.
        for (int f = 1; f <= 5; f++) begin
            applyStimulus(8'(f), 1'b1, ^8'(f));
            serial_in = 1'b1;
            cycles(6);
            if (f == 4) begin
                checkOutput("full after 4", {31'd0, fifo_full}, 32'd1);
                checkOutput("level after 4", {29'd0, fifo_level}, 32'd4);
                checkOutput("no overrun at 4", {31'd0, overrun}, 32'd0);
            end
        end
        checkOutput("overrun after 5", {31'd0, overrun}, 32'd1);
        checkOutput("level after 5", {29'd0, fifo_level}, 32'd4);
        for (int r = 1; r <= 4; r++) begin
            checkOutput($sformatf("read %0d", r), {24'd0, rd_data}, r);
            popOne();
        end
        checkOutput("drained empty", {31'd0, fifo_empty}, 32'd1);
        checkOutput("overrun sticky", {31'd0, overrun}, 32'd1);
        pulseClear();
        checkOutput("overrun cleared", {31'd0, overrun}, 32'd0);

        // Stop bit low followed by a long break.
        applyStimulus(8'h3C, 1'b0, ^8'h3C);
        serial_in = 1'b0;
        cycles(20 * CPB);
        checkOutput("break frame_error", {31'd0, frame_error}, 32'd1);
        checkOutput("break no push", {31'd0, fifo_empty}, 32'd1);
        serial_in = 1'b1;
        cycles(4);
        pulseClear();
        checkOutput("break cleared", {31'd0, frame_error}, 32'd0);
        applyStimulus(8'h3C, 1'b1, ^8'h3C);
        serial_in = 1'b1;
        waitValid("after break valid", 6);
        checkOutput("after break data", {24'd0, rd_data}, 32'h3C);
        checkOutput("after break no err", {31'd0, frame_error}, 32'd0);

        // Reset mid-frame with a word already buffered empties everything.
        serial_in = 1'b0;
        cycles(12);
        reset_n   = 1'b0;
        serial_in = 1'b1;
        cycles(2);
        checkOutput("midreset empty", {31'd0, fifo_empty}, 32'd1);
        checkOutput("midreset level", {29'd0, fifo_level}, 32'd0);
        checkOutput("midreset rd_data", {24'd0, rd_data}, 32'd0);
        reset_n = 1'b1;
        cycles(4);
        checkOutput("post reset idle", {31'd0, rd_valid}, 32'd0);
        applyStimulus(8'h33, 1'b1, ^8'h33);
        serial_in = 1'b1;
        waitValid("post reset valid", 6);
        checkOutput("post reset data", {24'd0, rd_data}, 32'h33);
        checkOutput("post reset level", {29'd0, fifo_level}, 32'd1);
        popOne();

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b0);
        serial_in = 1'b1;
        cycles(8);
        checkOutput("bad parity flag", {31'd0, parity_error}, 32'd1);
        checkOutput("bad parity no push", {31'd0, fifo_empty}, 32'd1);
        pulseClear();
        checkOutput("parity cleared", {31'd0, parity_error}, 32'd0);
        applyStimulus(8'h07, 1'b1, 1'b1);
        serial_in = 1'b1;
        waitValid("good parity valid", 6);
        checkOutput("good parity data", {24'd0, rd_data}, 32'h07);
        checkOutput("good parity no flag", {31'd0, parity_error}, 32'd0);
        popOne();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
